// File: rtl/axil_wr_decoder_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) for the window decoder.
// The master modport drives requests; the slave modport drives readies and the response.
interface axil_wr_decoder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/axil_wr_decoder.sv
// AXI4-Lite write slave decoding each write into a select register or one-hot mode enable; effects land 1 cycle after the last of AW/W.
// One write in flight: AW/W stall while BVALID waits on BREADY. Define AXIL_WR_DECODER_ERR_IRQ_EN for the sticky DECERR interrupt.
module axil_wr_decoder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_TGT = 4,
    parameter int WIN_LG2 = 8,
    parameter int SEL_W   = 2
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axil_wr_decoder_if.slave   s_axi,
    output logic [SEL_W-1:0]   sel_out,
    output logic [NUM_TGT-1:0] tgt_en,
    output logic [NUM_TGT-1:0] tgt_wr,
    output logic               err_irq
);
    localparam int IDX_W  = ADDR_W - WIN_LG2;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, HAVE_A, HAVE_W, RESP} state_t;

    state_t              r_state;
    logic                r_awready;
    logic                r_wready;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [SEL_W-1:0]    r_sel;
    logic [NUM_TGT-1:0]  r_tgt_en;
    logic [NUM_TGT-1:0]  r_tgt_wr;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_go;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic [IDX_W-1:0]    w_idx;
    logic                w_dec_err;
    logic                w_win0;
    logic [NUM_TGT-1:0]  w_onehot;
    logic                w_irq_clr;
    logic                w_unused;

    assign w_aw_hs = s_axi.AWVALID && r_awready;
    assign w_w_hs  = s_axi.WVALID && r_wready;

    // The write completes once both halves are held, either captured earlier or handshaking now.
    assign w_go = (r_state != RESP)
               && (w_aw_hs || (r_state == HAVE_A))
               && (w_w_hs  || (r_state == HAVE_W));

    assign w_addr  = (r_state == HAVE_A) ? r_addr  : s_axi.AWADDR;
    assign w_wdata = (r_state == HAVE_W) ? r_wdata : s_axi.WDATA;
    assign w_wstrb = (r_state == HAVE_W) ? r_wstrb : s_axi.WSTRB;

    assign w_idx     = w_addr[ADDR_W-1:WIN_LG2];
    assign w_dec_err = (w_idx >= IDX_W'(NUM_TGT));
    assign w_win0    = (w_idx == '0);
    assign w_onehot  = NUM_TGT'(1) << w_idx;
    assign w_unused  = ^{w_addr, w_wdata, w_wstrb};

`ifdef AXIL_WR_DECODER_ERR_IRQ_EN
    logic r_err_irq;
    assign w_irq_clr = w_win0 && w_wdata[31];
    assign err_irq   = r_err_irq;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err_irq <= 1'b0;
        end else if (w_go) begin
            if (w_dec_err)
                r_err_irq <= 1'b1;
            else if (w_irq_clr)
                r_err_irq <= 1'b0;
        end
    end
`else
    assign w_irq_clr = 1'b0;
    assign err_irq   = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_sel     <= '0;
            r_tgt_en  <= '0;
            r_tgt_wr  <= '0;
        end else begin
            r_tgt_wr <= '0;
            case (r_state)
                IDLE: begin
                    if (w_aw_hs && !w_w_hs) begin
                        r_addr    <= s_axi.AWADDR;
                        r_awready <= 1'b0;
                        r_state   <= HAVE_A;
                    end else if (w_w_hs && !w_aw_hs) begin
                        r_wdata  <= s_axi.WDATA;
                        r_wstrb  <= s_axi.WSTRB;
                        r_wready <= 1'b0;
                        r_state  <= HAVE_W;
                    end
                end
                RESP: begin
                    if (s_axi.BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: ;
            endcase

            if (w_go) begin
                r_state   <= RESP;
                r_awready <= 1'b0;
                r_wready  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_dec_err ? 2'b11 : 2'b00;
                if (!w_dec_err) begin
                    r_tgt_wr <= w_onehot;
                    // Window 0 only touches the select register; tgt_en keeps its last mode.
                    if (w_win0) begin
                        if (w_wstrb[0] && !w_irq_clr)
                            r_sel <= w_wdata[SEL_W-1:0];
                    end else begin
                        r_tgt_en <= w_onehot;
                    end
                end
            end
        end
    end

    assign s_axi.AWREADY = r_awready;
    assign s_axi.WREADY  = r_wready;
    assign s_axi.BVALID  = r_bvalid;
    assign s_axi.BRESP   = r_bresp;
    assign sel_out       = r_sel;
    assign tgt_en        = r_tgt_en;
    assign tgt_wr        = r_tgt_wr;
endmodule
